// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels, the shared register-file
// write port and the read-address hazard check of regfile_write_arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REGBITS    = 4
);
    logic                  a_valid;
    logic                  a_ready;
    logic [REGBITS-1:0]    a_addr;
    logic [DATA_WIDTH-1:0] a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [REGBITS-1:0]    b_addr;
    logic [DATA_WIDTH-1:0] b_data;

    logic                  writeEn;
    logic [REGBITS-1:0]    dstAddr;
    logic [DATA_WIDTH-1:0] writeData;

    logic [REGBITS-1:0]    srcAddr;
    logic [REGBITS-1:0]    srcAddr2;
    logic                  hazard;

    logic                  busy;
    logic                  last_grant;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output srcAddr, srcAddr2,
        input  a_ready, b_ready,
        input  writeEn, dstAddr, writeData,
        input  hazard, busy, last_grant
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  srcAddr, srcAddr2,
        output a_ready, b_ready,
        output writeEn, dstAddr, writeData,
        output hazard, busy, last_grant
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU
// (A) and load (B) writeback paths, each buffered by a 2-entry queue.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int REGBITS    = 4
) (
    input logic                   clk,
    input logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    // Index 0 is requester A, index 1 is requester B.
    logic [REGBITS-1:0]    q_addr [2][2];
    logic [DATA_WIDTH-1:0] q_data [2][2];
    logic                  head   [2];
    logic                  tail   [2];
    logic [1:0]            count  [2];

    logic                  in_valid [2];
    logic [REGBITS-1:0]    in_addr  [2];
    logic [DATA_WIDTH-1:0] in_data  [2];
    logic                  ready    [2];
    logic                  push     [2];
    logic                  pop      [2];

    logic                  pop_any;
    logic                  grant_b;
    logic [REGBITS-1:0]    head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic                  write_en_q;
    logic [REGBITS-1:0]    dst_addr_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic                  last_grant_q;
    logic                  hazard_c;

    always_comb begin
        in_valid[0] = bus.a_valid;
        in_addr[0]  = bus.a_addr;
        in_data[0]  = bus.a_data;
        in_valid[1] = bus.b_valid;
        in_addr[1]  = bus.b_addr;
        in_data[1]  = bus.b_data;
        for (int i = 0; i < 2; i++) begin
            ready[i] = (count[i] != 2'd2);
            push[i]  = in_valid[i] && ready[i];
        end
    end

    // On a tie the side that did not win last time is served; last_grant=1 means B won last.
    always_comb begin
        pop_any = 1'b0;
        grant_b = 1'b0;
        if (count[0] != 2'd0 && count[1] != 2'd0) begin
            pop_any = 1'b1;
            grant_b = ~last_grant_q;
        end else if (count[0] != 2'd0) begin
            pop_any = 1'b1;
        end else if (count[1] != 2'd0) begin
            pop_any = 1'b1;
            grant_b = 1'b1;
        end
        pop[0]    = pop_any && !grant_b;
        pop[1]    = pop_any && grant_b;
        head_addr = q_addr[grant_b][head[grant_b]];
        head_data = q_data[grant_b][head[grant_b]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                q_addr[i][tail[i]] <= in_addr[i];
                q_data[i][tail[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                head[i]  <= 1'b0;
                tail[i]  <= 1'b0;
                count[i] <= 2'd0;
            end
            write_en_q   <= 1'b0;
            dst_addr_q   <= '0;
            write_data_q <= '0;
            last_grant_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) tail[i] <= ~tail[i];
                if (pop[i])  head[i] <= ~head[i];
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
            end
            write_en_q <= pop_any;
            if (pop_any) begin
                dst_addr_q   <= head_addr;
                write_data_q <= head_data;
                last_grant_q <= grant_b;
            end
        end
    end

    // A queue slot is live when the queue is full, or it is the head of a one-entry queue.
    always_comb begin
        hazard_c = write_en_q &&
                   (dst_addr_q == bus.srcAddr || dst_addr_q == bus.srcAddr2);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if ((count[i] == 2'd2 || (count[i] == 2'd1 && head[i] == 1'(j))) &&
                    (q_addr[i][j] == bus.srcAddr || q_addr[i][j] == bus.srcAddr2))
                    hazard_c = 1'b1;
            end
        end
    end

    assign bus.a_ready    = ready[0];
    assign bus.b_ready    = ready[1];
    assign bus.writeEn    = write_en_q;
    assign bus.dstAddr    = dst_addr_q;
    assign bus.writeData  = write_data_q;
    assign bus.last_grant = last_grant_q;
    assign bus.hazard     = hazard_c;
    assign bus.busy       = (count[0] != 2'd0) || (count[1] != 2'd0) || write_en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: latency, round-robin order,
// queue back-pressure, hazard window and mid-operation reset.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] rf_model [16];

    regfile_write_arbiter_if #(.DATA_WIDTH(16), .REGBITS(4)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(16), .REGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the arbiter output, to check the final value after same-address writes.
    always @(posedge clk) begin
        if (bus.writeEn) rf_model[bus.dstAddr] <= bus.writeData;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                  input logic bv, input logic [3:0] ba, input logic [15:0] bd);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_write(input string tag, input logic [3:0] addr, input logic [15:0] data);
        check_output({tag, "_en"},   32'(bus.writeEn),   32'd1);
        check_output({tag, "_addr"}, 32'(bus.dstAddr),   32'(addr));
        check_output({tag, "_data"}, 32'(bus.writeData), 32'(data));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 16; k++) rf_model[k] = 16'h0;
        reset        = 1'b1;
        bus.srcAddr  = 4'd0;
        bus.srcAddr2 = 4'd0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_writeEn",    32'(bus.writeEn),    32'd0);
        check_output("rst_dstAddr",    32'(bus.dstAddr),    32'd0);
        check_output("rst_writeData",  32'(bus.writeData),  32'd0);
        check_output("rst_last_grant", 32'(bus.last_grant), 32'd1);
        check_output("rst_a_ready",    32'(bus.a_ready),    32'd1);
        check_output("rst_b_ready",    32'(bus.b_ready),    32'd1);
        check_output("rst_hazard",     32'(bus.hazard),     32'd0);
        check_output("rst_busy",       32'(bus.busy),       32'd0);

        $display("[TB] single A write latency");
        apply_stimulus(1, 4'd3, 16'h1234, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("lat_e0_writeEn", 32'(bus.writeEn), 32'd0);
        check_output("lat_e0_busy",    32'(bus.busy),    32'd1);
        step();
        check_write("lat_e1", 4'd3, 16'h1234);
        check_output("lat_e1_last_grant", 32'(bus.last_grant), 32'd0);
        step();
        check_output("lat_e2_writeEn", 32'(bus.writeEn), 32'd0);
        check_output("lat_e2_busy",    32'(bus.busy),    32'd0);
        check_output("lat_e2_dstHold", 32'(bus.dstAddr), 32'd3);

        $display("[TB] A back-pressure while B contends");
        apply_stimulus(1, 4'd7, 16'h0007, 1, 4'd12, 16'h000C);
        step();
        apply_stimulus(1, 4'd8, 16'h0008, 1, 4'd13, 16'h000D);
        step();
        check_write("bp_b12", 4'd12, 16'h000C);
        check_output("bp_a_ready_full", 32'(bus.a_ready), 32'd0);
        apply_stimulus(1, 4'd9, 16'h0009, 0, 0, 0);
        step();
        check_write("bp_a7", 4'd7, 16'h0007);
        check_output("bp_a_ready_back", 32'(bus.a_ready), 32'd1);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_write("bp_b13", 4'd13, 16'h000D);
        step();
        check_write("bp_a8", 4'd8, 16'h0008);
        step();
        check_write("bp_a9", 4'd9, 16'h0009);
        step();
        check_output("bp_done_writeEn", 32'(bus.writeEn), 32'd0);
        check_output("bp_done_busy",    32'(bus.busy),    32'd0);

        $display("[TB] round-robin order from reset");
        reset = 1'b1;
        step();
        reset = 1'b0;
        apply_stimulus(1, 4'd1, 16'h0001, 1, 4'd5, 16'h0005);
        step();
        apply_stimulus(1, 4'd2, 16'h0002, 1, 4'd6, 16'h0006);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_write("rr_r1", 4'd1, 16'h0001);
        step();
        check_write("rr_r5", 4'd5, 16'h0005);
        step();
        check_write("rr_r2", 4'd2, 16'h0002);
        step();
        check_write("rr_r6", 4'd6, 16'h0006);
        step();
        check_output("rr_done_writeEn", 32'(bus.writeEn), 32'd0);

        $display("[TB] hazard window");
        bus.srcAddr  = 4'd10;
        bus.srcAddr2 = 4'd0;
        #1;
        check_output("hz_idle", 32'(bus.hazard), 32'd0);
        apply_stimulus(0, 0, 0, 1, 4'd10, 16'h0A0A);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("hz_queued", 32'(bus.hazard), 32'd1);
        bus.srcAddr  = 4'd11;
        bus.srcAddr2 = 4'd10;
        #1;
        check_output("hz_queued_src2", 32'(bus.hazard), 32'd1);
        bus.srcAddr  = 4'd10;
        bus.srcAddr2 = 4'd0;
        step();
        check_output("hz_outstage", 32'(bus.hazard),  32'd1);
        check_output("hz_out_en",   32'(bus.writeEn), 32'd1);
        step();
        check_output("hz_cleared",  32'(bus.hazard),  32'd0);
        bus.srcAddr  = 4'd11;
        bus.srcAddr2 = 4'd11;
        apply_stimulus(0, 0, 0, 1, 4'd10, 16'h0A0B);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("hz_miss_queued", 32'(bus.hazard), 32'd0);
        step();
        check_output("hz_miss_out",    32'(bus.hazard), 32'd0);
        step();
        check_output("hz_miss_after",  32'(bus.hazard), 32'd0);

        $display("[TB] reset mid-operation");
        apply_stimulus(1, 4'd0, 16'h0000, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_output("mr_pre_last_grant", 32'(bus.last_grant), 32'd0);
        apply_stimulus(1, 4'd1, 16'h0011, 1, 4'd6, 16'h0066);
        step();
        apply_stimulus(1, 4'd2, 16'h0022, 0, 0, 0);
        step();
        check_write("mr_b6", 4'd6, 16'h0066);
        check_output("mr_a_full", 32'(bus.a_ready), 32'd0);
        apply_stimulus(1, 4'd3, 16'h0033, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("mr_writeEn",    32'(bus.writeEn),    32'd0);
        check_output("mr_busy",       32'(bus.busy),       32'd0);
        check_output("mr_a_ready",    32'(bus.a_ready),    32'd1);
        check_output("mr_last_grant", 32'(bus.last_grant), 32'd1);
        step();
        check_output("mr_quiet1", 32'(bus.writeEn), 32'd0);
        step();
        check_output("mr_quiet2", 32'(bus.writeEn), 32'd0);

        $display("[TB] same-register writes from both sides");
        apply_stimulus(1, 4'd0, 16'h0000, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_output("sr_pre_last_grant", 32'(bus.last_grant), 32'd0);
        apply_stimulus(1, 4'd4, 16'hAAAA, 1, 4'd4, 16'hBBBB);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step();
        check_write("sr_first_b", 4'd4, 16'hBBBB);
        step();
        check_write("sr_second_a", 4'd4, 16'hAAAA);
        step();
        check_output("sr_rf_r4", 32'(rf_model[4]), 32'hAAAA);
        check_output("sr_done_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
